io_mmio_ctrl: RTL and testbench
===============================

# io_mmio_ctrl

Parametrised memory-mapped IO controller for the RISC-V core. It decodes IO-space loads and stores from the memory stage and buffers UART traffic in independent TX and RX FIFOs. It also keeps cycle and retired-instruction counters and returns registered read data to the writeback mux. It is the FIFO-buffered, counter-equipped successor to the core's unbuffered IO interface.

## Interface
- `FIFO_DEPTH`, default 8: entries per FIFO. Must be a power of 2 and ≥2.
- `DATA_WIDTH`, default 8: UART character width. Must be ≤32.
- `clk` input, 1 bit: sole clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `A` input, 32 bits: memory-stage byte address. Bit 31 set selects IO space.
- `io_trans` input, 4 bits: store byte-enables. Any nonzero value with `A[31]=1` is an IO write.
- `io_recv` input, 1 bit: load strobe. High with `A[31]=1` is an IO read.
- `wdata` input, 32 bits: store data.
- `instr_retire` input, 1 bit: one instruction retired this cycle.
- `Received` output, 32 bits: registered read data.
- `uart_tx_data` output, `DATA_WIDTH` bits: character to UART transmitter.
- `uart_tx_valid` output, 1 bit: TX FIFO not empty.
- `uart_tx_ready` input, 1 bit: transmitter accepts a character.
- `uart_rx_data` input, `DATA_WIDTH` bits: character from UART receiver.
- `uart_rx_valid` input, 1 bit: receiver presents a character.
- `uart_rx_ready` output, 1 bit: RX FIFO not full.

## Operation
- Decode uses `A[5:2]` only, and only when `A[31]=1`. Otherwise the block ignores the access and `Received` loads 0.
- Register map (offsets):
  - 0x00 TX status (R): bit0 = TX not full.
  - 0x04 RX status (R): bit0 = RX not empty.
  - 0x08 TX data (W): push `wdata[DATA_WIDTH-1:0]`.
  - 0x0C RX data (R): pop; returns the character zero-extended.
  - 0x10 cycle counter (R).
  - 0x14 instruction counter (R).
  - 0x18 counter reset (W, any data): clears both counters.
  - 0x1C error (R/W1C): bit0 TX overflow, bit1 RX overflow, bit2 RX underflow. A write clears each bit whose `wdata` bit is 1.
  - Unmapped offsets read 0; writes to them are ignored.
- TX FIFO:
  - Push on an IO write to 0x08.
  - A push while full is dropped and sets the TX overflow bit.
  - A pop occurs when `uart_tx_valid && uart_tx_ready`.
  - `uart_tx_data` always shows the head entry, combinationally from FIFO storage.
- RX FIFO:
  - Push when `uart_rx_valid && uart_rx_ready`.
  - `uart_rx_valid` while full does not push and sets the RX overflow bit.
  - A pop occurs on an IO read of 0x0C.
  - A read of 0x0C while empty returns 0, does not move pointers, and sets the RX underflow bit.
- FIFO implementation: read/write pointers of width log2(`FIFO_DEPTH`)+1. The extra MSB distinguishes full from empty; pointers wrap modulo 2×`FIFO_DEPTH`.
- Simultaneous push and pop:
  - Not full and not empty: both occur; occupancy is unchanged.
  - Empty: only the push occurs; there is no bypass.
  - Full: the pop occurs and the push is accepted in the same cycle. No overflow is flagged.
- Counters are 32 bits and wrap 0xFFFFFFFF→0.
  - Cycle counter increments every cycle.
  - Instruction counter increments when `instr_retire` is high.
  - A counter-reset write wins over an increment in the same cycle: the counter is 0 next cycle.
- An IO read and an IO write in the same cycle: the write takes effect and the read returns the pre-write state.

## Timing
- Reset (`rst` high at a clock edge):
  - FIFOs empty, counters 0, error bits 0, `Received`=0.
  - As a result `uart_tx_valid`=0 and `uart_rx_ready`=1.
  - `rst` asserted mid-transfer discards all FIFO contents. The UART-side handshake in that cycle is not completed.
- Read latency is 1 cycle. `Received` updates at the edge after the `io_recv` cycle and holds until the next IO read or reset.
- Status reads reflect state before any same-cycle push or pop.
- Write latency: push, counter clear and W1C take effect at the same edge; they are visible to a read issued the next cycle.
- Handshakes: `uart_tx_valid` and `uart_rx_ready` are functions of registered pointers only. There is no combinational path from `uart_tx_ready` or `uart_rx_valid` to them.
- Throughput: one push and one pop per FIFO per cycle.

## Test plan
- Reset, then read 0x10 twice, 3 cycles apart → second value = first + 3. Read 0x00 → 1. Read 0x04 → 0. `uart_rx_ready`=1.
- With `uart_tx_ready`=0, write 'A'..'I' (9 chars) with `FIFO_DEPTH`=8 → TX status bit0 = 0 after the 8th. Error reg reads 0x1. Raise ready → exactly 'A'..'H' appear in order, one per cycle.
- Drive `uart_rx_valid` with 0x55 then 0xAA. Read 0x04 → 1. Read 0x0C twice → 0x00000055, then 0x000000AA. A third read → 0 and error bit2 set. Write 0x4 to 0x1C → error reads 0.
- Fill RX to 8, then assert an RX push in the same cycle as a 0x0C read → occupancy stays 8 and no overflow. A 9th push with no read → overflow bit1 set and data unchanged.
- Pulse `instr_retire` 5 times, then write 0x18 in a cycle where `instr_retire`=1 → next read of 0x14 returns 0.
- Preload the cycle counter to near-wrap via long run or force → 0xFFFFFFFF is followed by 0. Asserting `rst` with both FIFOs half full → all outputs at reset values next cycle.

Source files
------------

// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl
// Memory-mapped IO controller for the RISC-V core. Decodes IO-space loads and
// stores from the memory stage (A[31]=1, offset A[5:2]), buffers UART traffic
// in independent TX and RX FIFOs, keeps free-running cycle and retired
// instruction counters, and returns registered read data to writeback.
//
// Ports
//   clk            : sole clock
//   rst            : synchronous active-high reset
//   A              : memory-stage byte address, bit 31 selects IO space
//   io_trans       : store byte-enables (nonzero with A[31] = IO write)
//   io_recv        : load strobe (with A[31] = IO read)
//   wdata          : store data
//   instr_retire   : one instruction retired this cycle
//   Received       : registered read data (1-cycle latency)
//   uart_tx_data   : head of TX FIFO towards UART transmitter
//   uart_tx_valid  : TX FIFO not empty
//   uart_tx_ready  : transmitter accepts a character
//   uart_rx_data   : character from UART receiver
//   uart_rx_valid  : receiver presents a character
//   uart_rx_ready  : RX FIFO not full
//
// Register map (byte offsets): 0x00 TX status, 0x04 RX status, 0x08 TX data,
// 0x0C RX data (pop), 0x10 cycle counter, 0x14 instruction counter,
// 0x18 counter clear, 0x1C error (W1C: bit0 TX ovf, bit1 RX ovf, bit2 RX udf).
module io_mmio_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           A,
    input  logic [3:0]            io_trans,
    input  logic                  io_recv,
    input  logic [31:0]           wdata,
    input  logic                  instr_retire,
    output logic [31:0]           Received,
    output logic [DATA_WIDTH-1:0] uart_tx_data,
    output logic                  uart_tx_valid,
    input  logic                  uart_tx_ready,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    input  logic                  uart_rx_valid,
    output logic                  uart_rx_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [3:0] OFF_TX_STAT = 4'd0;
    localparam logic [3:0] OFF_RX_STAT = 4'd1;
    localparam logic [3:0] OFF_TX_DATA = 4'd2;
    localparam logic [3:0] OFF_RX_DATA = 4'd3;
    localparam logic [3:0] OFF_CYC     = 4'd4;
    localparam logic [3:0] OFF_INSTR   = 4'd5;
    localparam logic [3:0] OFF_CNT_CLR = 4'd6;
    localparam logic [3:0] OFF_ERR     = 4'd7;

    // ---------------------------------------------------------------- state
    logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW:0]           r_tx_wptr;
    logic [AW:0]           r_tx_rptr;
    logic [AW:0]           r_rx_wptr;
    logic [AW:0]           r_rx_rptr;
    logic [31:0]           r_cyc_cnt;
    logic [31:0]           r_instr_cnt;
    logic [2:0]            r_err;
    logic [31:0]           r_received;

    // ---------------------------------------------------------------- wires
    logic        w_io_sel;
    logic [3:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic        w_tx_pop;
    logic        w_tx_push_req;
    logic        w_tx_push;
    logic        w_tx_ovf;
    logic        w_rx_empty;
    logic        w_rx_full;
    logic        w_rx_rd_req;
    logic        w_rx_pop;
    logic        w_rx_udf;
    logic        w_rx_push;
    logic        w_rx_ovf;
    logic        w_cnt_clr;
    logic [2:0]  w_err_set;
    logic [2:0]  w_err_clr;
    logic [31:0] w_rx_head_ext;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Address bits outside the decoded window and upper store data are ignored.
    assign w_unused = ^{A[30:6], A[1:0], wdata};

    assign w_io_sel = A[31];
    assign w_off    = A[5:2];
    assign w_wr     = w_io_sel & (|io_trans);
    assign w_rd     = w_io_sel & io_recv;

    // Full when the pointers differ only in the wrap bit.
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                        (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                        (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);

    // Handshake outputs depend on registered pointers only.
    assign uart_tx_valid = ~w_tx_empty;
    assign uart_rx_ready = ~w_rx_full;
    assign uart_tx_data  = r_tx_mem[r_tx_rptr[AW-1:0]];
    assign Received      = r_received;

    // TX: a push into a full FIFO is still accepted when the head leaves in
    // the same cycle, because the freed slot is the one being written.
    assign w_tx_pop      = uart_tx_valid & uart_tx_ready;
    assign w_tx_push_req = w_wr & (w_off == OFF_TX_DATA);
    assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
    assign w_tx_ovf      = w_tx_push_req & w_tx_full & ~w_tx_pop;

    // RX: same full-with-pop rule; uart_rx_ready stays low while full, but a
    // character offered in a popping cycle is taken.
    assign w_rx_rd_req = w_rd & (w_off == OFF_RX_DATA);
    assign w_rx_pop    = w_rx_rd_req & ~w_rx_empty;
    assign w_rx_udf    = w_rx_rd_req & w_rx_empty;
    assign w_rx_push   = uart_rx_valid & (~w_rx_full | w_rx_pop);
    assign w_rx_ovf    = uart_rx_valid & w_rx_full & ~w_rx_pop;

    assign w_cnt_clr = w_wr & (w_off == OFF_CNT_CLR);
    assign w_err_set = {w_rx_udf, w_rx_ovf, w_tx_ovf};

    // W1C mask for the error register.
    always_comb begin
        w_err_clr = 3'b000;
        if (w_wr && (w_off == OFF_ERR)) begin
            w_err_clr = wdata[2:0];
        end else begin
            w_err_clr = 3'b000;
        end
    end

    // Zero-extend the RX head to 32 bits (works for DATA_WIDTH up to 32).
    always_comb begin
        w_rx_head_ext = 32'd0;
        w_rx_head_ext[DATA_WIDTH-1:0] = r_rx_mem[r_rx_rptr[AW-1:0]];
    end

    // Read mux: reflects state before any same-cycle push/pop/clear.
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_TX_STAT: w_rdata = {31'd0, ~w_tx_full};
            OFF_RX_STAT: w_rdata = {31'd0, ~w_rx_empty};
            OFF_RX_DATA: w_rdata = w_rx_empty ? 32'd0 : w_rx_head_ext;
            OFF_CYC:     w_rdata = r_cyc_cnt;
            OFF_INSTR:   w_rdata = r_instr_cnt;
            OFF_ERR:     w_rdata = {29'd0, r_err};
            default:     w_rdata = 32'd0;
        endcase
    end

    // TX FIFO storage (contents need no reset; pointers define validity).
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr[AW-1:0]] <= wdata[DATA_WIDTH-1:0];
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr[AW-1:0]] <= uart_rx_data;
        end
    end

    // FIFO pointers; reset discards contents and cancels that cycle's handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
        end
    end

    // Counters: a clear write beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr) begin
            r_cyc_cnt   <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (instr_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    // Sticky error bits; a new event in the clearing cycle keeps its bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 3'b000;
        end else begin
            r_err <= (r_err & ~w_err_clr) | w_err_set;
        end
    end

    // Registered read data; a load outside IO space returns 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_received <= 32'd0;
        end else if (io_recv) begin
            r_received <= w_rd ? w_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl (FIFO_DEPTH=8, DATA_WIDTH=8).
module tb_io_mmio_ctrl;

    localparam logic [31:0] R_TX_STAT = 32'h8000_0000;
    localparam logic [31:0] R_RX_STAT = 32'h8000_0004;
    localparam logic [31:0] R_TX_DATA = 32'h8000_0008;
    localparam logic [31:0] R_RX_DATA = 32'h8000_000C;
    localparam logic [31:0] R_CYC     = 32'h8000_0010;
    localparam logic [31:0] R_INSTR   = 32'h8000_0014;
    localparam logic [31:0] R_CNT_CLR = 32'h8000_0018;
    localparam logic [31:0] R_ERR     = 32'h8000_001C;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [3:0]  io_trans;
    logic        io_recv;
    logic [31:0] wdata;
    logic        instr_retire;
    logic [31:0] Received;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int n_pass;
    int n_total;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    io_mmio_ctrl #(.FIFO_DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .io_trans     (io_trans),
        .io_recv      (io_recv),
        .wdata        (wdata),
        .instr_retire (instr_retire),
        .Received     (Received),
        .uart_tx_data (uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic io_read(input logic [31:0] addr, output logic [31:0] d);
        A = addr;
        io_recv = 1'b1;
        tick();
        io_recv = 1'b0;
        A = 32'd0;
        d = Received;
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
        A = addr;
        io_trans = 4'hF;
        wdata = data;
        tick();
        io_trans = 4'h0;
        wdata = 32'd0;
        A = 32'd0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        io_read(addr, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        A = 32'd0;
        io_trans = 4'h0;
        io_recv = 1'b0;
        wdata = 32'd0;
        instr_retire = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data = 8'h00;
        uart_rx_valid = 1'b0;

        // Register-access vectors applied after two RX characters arrive.
        tbl[0]  = '{1'b0, R_RX_STAT,     32'h0, 32'h1};
        tbl[1]  = '{1'b0, R_RX_DATA,     32'h0, 32'h55};
        tbl[2]  = '{1'b0, R_RX_DATA,     32'h0, 32'hAA};
        tbl[3]  = '{1'b0, R_RX_DATA,     32'h0, 32'h0};
        tbl[4]  = '{1'b0, R_ERR,         32'h0, 32'h4};
        tbl[5]  = '{1'b0, 32'h0000_001C, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, R_ERR,         32'h4, 32'h0};
        tbl[7]  = '{1'b0, R_ERR,         32'h0, 32'h0};
        tbl[8]  = '{1'b1, R_RX_DATA,     32'hFF, 32'h0};
        tbl[9]  = '{1'b0, R_RX_STAT,     32'h0, 32'h0};
        tbl[10] = '{1'b0, R_TX_DATA,     32'h0, 32'h0};
        tbl[11] = '{1'b0, 32'h8000_0020, 32'h0, 32'h0};

        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_received", Received, 32'd0);
        check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd1);

        // Cycle counter advances by 3 across reads 3 cycles apart
        io_read(R_CYC, v1);
        tick();
        tick();
        io_read(R_CYC, v2);
        check("cyc_delta", v2, v1 + 32'd3);
        read_check("tx_stat_init", R_TX_STAT, 32'h1);
        read_check("rx_stat_init", R_RX_STAT, 32'h0);

        // TX fill to full, overflow on the 9th character
        for (int i = 0; i < 8; i++) io_write(R_TX_DATA, 32'h41 + i);
        read_check("tx_stat_full", R_TX_STAT, 32'h0);
        check("tx_valid_full", {31'd0, uart_tx_valid}, 32'd1);
        io_write(R_TX_DATA, 32'h49);
        read_check("tx_ovf_err", R_ERR, 32'h1);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_drain%0d", i), {23'd0, uart_tx_valid, uart_tx_data},
                  {23'd0, 1'b1, 8'h41 + 8'(i)});
            tick();
        end
        check("tx_empty_after", {31'd0, uart_tx_valid}, 32'd0);
        uart_tx_ready = 1'b0;
        io_write(R_ERR, 32'h1);

        // RX two characters, then table of register accesses
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h55;
        tick();
        uart_rx_data = 8'hAA;
        tick();
        uart_rx_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                io_write(tbl[i].addr, tbl[i].wdata);
            end else begin
                read_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
            end
        end

        // RX full: simultaneous push and pop keeps occupancy, no overflow
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            uart_rx_data = 8'h10 + 8'(i);
            tick();
        end
        uart_rx_valid = 1'b0;
        check("rx_full_ready", {31'd0, uart_rx_ready}, 32'd0);
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h99;
        A = R_RX_DATA;
        io_recv = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        io_recv = 1'b0;
        A = 32'd0;
        check("rx_pushpop_data", Received, 32'h10);
        check("rx_pushpop_ready", {31'd0, uart_rx_ready}, 32'd0);
        read_check("rx_pushpop_err", R_ERR, 32'h0);
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h77;
        tick();
        uart_rx_valid = 1'b0;
        read_check("rx_ovf_err", R_ERR, 32'h2);
        for (int i = 1; i < 8; i++) read_check($sformatf("rx_drain%0d", i), R_RX_DATA, 32'h10 + i);
        read_check("rx_drain_last", R_RX_DATA, 32'h99);
        read_check("rx_empty_after", R_RX_STAT, 32'h0);
        io_write(R_ERR, 32'h2);

        // Instruction counter and clear-beats-increment
        for (int i = 0; i < 5; i++) begin
            instr_retire = 1'b1;
            tick();
            instr_retire = 1'b0;
            tick();
        end
        read_check("instr_5", R_INSTR, 32'd5);
        instr_retire = 1'b1;
        io_write(R_CNT_CLR, 32'h0);
        instr_retire = 1'b0;
        read_check("instr_clr", R_INSTR, 32'd0);
        read_check("cyc_clr", R_CYC, 32'd1);

        // Cycle counter wrap
        dut.r_cyc_cnt = 32'hFFFF_FFFF;
        read_check("cyc_max", R_CYC, 32'hFFFF_FFFF);
        read_check("cyc_wrap", R_CYC, 32'h0);

        // Reset with both FIFOs half full and handshakes offered
        for (int i = 0; i < 4; i++) io_write(R_TX_DATA, 32'h61 + i);
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_rx_data = 8'h30 + 8'(i);
            tick();
        end
        uart_rx_valid = 1'b0;
        read_check("pre_rst_rx_stat", R_RX_STAT, 32'h1);
        rst = 1'b1;
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'hEE;
        tick();
        rst = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        check("rst2_received", Received, 32'd0);
        check("rst2_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("rst2_rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        read_check("rst2_cyc", R_CYC, 32'd0);
        read_check("rst2_rx_stat", R_RX_STAT, 32'h0);
        read_check("rst2_tx_stat", R_TX_STAT, 32'h1);
        read_check("rst2_err", R_ERR, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
